k6502_timing: RTL and testbench
===============================

# k6502_timing

Instruction timing and control sequencer for the k6502 core. Sits directly upstream of the `k6502` datapath and drives its `control_signals_t` bundle every cycle, one state per `ph0` cycle. It runs the reset-vector fetch, latches opcodes from the pre-decode register into an instruction register, and sequences a first instruction subset (immediate loads, register transfers, `JMP abs`, `NOP`). Cycle counts are not yet NMOS-exact; this block establishes the control path that later opcode groups extend.

## Interface
- No parameters.
- `ph0` (input, 1): the single clock. All state updates on its rising edge.
- `reset_n` (input, 1): asynchronous, active-low reset.
- `pd` (input, 8): pre-decode register output, i.e. the byte read in the previous cycle.
- `rdy` (input, 1): high = advance. Low = stall.
- `ctl` (output, `control_signals_t`): datapath control bundle.
- `ir` (output, 8): instruction register. Resets to `8'hEA`.
- `sync` (output, 1): high in state T1, the opcode-latch cycle.
- `illegal` (output, 1): high in T2 of an unsupported opcode.

## Operation
- **HOLD pattern**: `pcl_pcl=pch_pch=1`, all other `ctl` bits 0. This is the default in every state, and unlisted bits below are 0.
- **FETCH pattern**: HOLD plus `pcl_adl, adl_abl, pch_adh, adh_abh, i_pc`.
- **States**: RST, RV0, RV1, RV2, T1, T2, T3.
- **RST** (held while `reset_n=0`). `ctl`=HOLD, `sync=0`, `illegal=0`, `ir=EA`. Next: RV0.
- **RV0**: drives `z_adl0, z_adl1, adl_abl, adh_abh`, so the address is FFFC. Next: RV1.
- **RV1**: drives `z_adl1, adl_abl, adh_abh` (address FFFD). Also `dl_db, db_add, z_add`, so ADD ← vector low byte. Next: RV2.
- **RV2**: drives `dl_adh, adh_pch, adh_abh, add_sb_6_0, add_sb_7, add_adl, adl_pcl, adl_abl, i_pc`, with `pcl_pcl=pch_pch=0`. PC ← vector, and the address points at the first opcode. Next: T1.
- **T1**: `ir ← pd` on exit. `sync=1`. Drives FETCH, except `i_pc=0` for 1-byte opcodes. Next: T2.
- **T2**, by `ir`:
  - `A9`/`A2`/`A0` (LDA/LDX/LDY immediate): drives `dl_db, db_add, z_add`. Next: T3.
  - `AA, A8, 8A, 98` (TAX, TAY, TXA, TYA): drives source `*_sb`, destination `sb_*`, and FETCH. Next: T1.
  - `4C` (JMP abs): drives `dl_db, db_add, z_add` and FETCH. Next: T3.
  - `EA` (NOP): drives FETCH. Next: T1.
  - Any other opcode: drives FETCH, `illegal=1`. Next: T1.
- **T3**, by `ir`:
  - Immediate loads: drives `add_sb_6_0, add_sb_7`, the matching `sb_ac`/`sb_x`/`sb_y`, and FETCH. Next: T1.
  - `4C`: same bus pattern as RV2 (PC ← {DL, ADD}, then fetch). Next: T1.
- **Decode rule**: T1 outputs are decoded from `pd`. T2/T3 outputs are decoded from `ir`.
- **`rdy=0`**: state and `ir` hold, and `ctl`=HOLD, which blocks `i_pc` and all register loads. The step resumes in full when `rdy` returns high.
- **Reset mid-instruction**: reset immediately forces RST, sets `ir=EA`, and drops `sync`/`illegal`. No partial register write may occur after `reset_n` falls.
- **`rdy` in RST**: ignored. In RV0–RV2, `rdy=0` stalls the same as anywhere else.

## Timing
- `ctl`, `sync` and `illegal` are combinational from state, `ir` and `pd` (T1 only), and `rdy`. They are glitch-tolerant: the datapath samples them on phases.
- Reset to first T1: 4 rising edges after `reset_n` rises (RST→RV0→RV1→RV2→T1).
- Instruction lengths (T1 through the last state):
  - Transfers, NOP and illegal opcodes: 2 cycles.
  - Immediate loads and JMP abs: 3 cycles.
- `ir` updates only on a T1→T2 edge with `rdy=1`.

## Structure
- Move `control_signals_t` into a shared package `k6502_pkg`, and have `k6502` import it.
- `k6502_pkg` also holds:
  - the state enum `timing_state_t`;
  - opcode localparams (`OP_LDA_IMM=8'hA9`, …);
  - `CTL_HOLD` and `CTL_FETCH` constants.
- Sub-module `k6502_decode`: combinational opcode → instruction class (`IMM_A`, `IMM_X`, `IMM_Y`, `XFER`, `JMP_ABS`, `NOP`, `ILLEGAL`), plus the source/destination select for transfers.
- `k6502_timing` holds the state register, `ir`, and per-state `ctl` assembly.

## Test plan
- **Reset**: `reset_n` low for 3 cycles, then high, with `pd` = 34 in RV2 and DL = 12. Expect RV0 `z_adl0=z_adl1=adl_abl=1`, RV1 `z_adl0=0`, RV2 `adl_pcl=adh_pch=1`, then `sync=1` on the 4th edge.
- **LDX #$5A**: `pd=A2` in T1. Expect T2 `db_add=z_add=1` and T3 `sb_x=1` with FETCH. `sync` pulses every 3 cycles.
- **TYA**: `pd=98`. Expect T2 `y_sb=sb_ac=1` with FETCH, and T1 `i_pc=0`. Instruction length is 2.
- **JMP $C000**: `pd=4C`. Expect T1/T2 `i_pc=1` and T3 `dl_adh=adh_pch=add_adl=adl_pcl=1`, `pcl_pcl=0`.
- **Unknown opcode 02**: expect `illegal=1` in T2 only, and the next T1 after 2 cycles.
- **Stall and reset**: `rdy=0` for 2 cycles in T3 of LDA, giving `ctl`=HOLD and `sb_ac=0`. Then `rdy=1` gives `sb_ac=1`. Dropping `reset_n` in T2 gives RST with `ir=EA` before the next edge.

Source files
------------

// File: rtl/k6502_pkg.sv
// rtl/k6502_pkg.sv - shared k6502 types: control bundle, timing states, opcodes
// and instruction classes.
package k6502_pkg;

   typedef struct packed {
      logic pcl_pcl;
      logic pch_pch;
      logic pcl_adl;
      logic pch_adh;
      logic adl_abl;
      logic adh_abh;
      logic i_pc;
      logic z_adl0;
      logic z_adl1;
      logic z_adl2;
      logic dl_adh;
      logic adh_pch;
      logic adl_pcl;
      logic dl_db;
      logic db_add;
      logic z_add;
      logic add_adl;
      logic add_sb_6_0;
      logic add_sb_7;
      logic ac_sb;
      logic x_sb;
      logic y_sb;
      logic sb_ac;
      logic sb_x;
      logic sb_y;
   } control_signals_t;

   localparam control_signals_t CTL_HOLD = '{pcl_pcl: 1'b1, pch_pch: 1'b1, default: 1'b0};

   localparam control_signals_t CTL_FETCH = '{pcl_pcl: 1'b1, pch_pch: 1'b1,
                                              pcl_adl: 1'b1, adl_abl: 1'b1,
                                              pch_adh: 1'b1, adh_abh: 1'b1,
                                              i_pc: 1'b1, default: 1'b0};

   // PC <- {DL, ADD} and present it on the address bus; shared by RV2 and JMP T3.
   localparam control_signals_t CTL_PC_LOAD = '{dl_adh: 1'b1, adh_pch: 1'b1,
                                                adh_abh: 1'b1, add_sb_6_0: 1'b1,
                                                add_sb_7: 1'b1, add_adl: 1'b1,
                                                adl_pcl: 1'b1, adl_abl: 1'b1,
                                                i_pc: 1'b1, default: 1'b0};

   localparam logic [7:0] OP_LDA_IMM = 8'hA9;
   localparam logic [7:0] OP_LDX_IMM = 8'hA2;
   localparam logic [7:0] OP_LDY_IMM = 8'hA0;
   localparam logic [7:0] OP_TAX     = 8'hAA;
   localparam logic [7:0] OP_TAY     = 8'hA8;
   localparam logic [7:0] OP_TXA     = 8'h8A;
   localparam logic [7:0] OP_TYA     = 8'h98;
   localparam logic [7:0] OP_JMP_ABS = 8'h4C;
   localparam logic [7:0] OP_NOP     = 8'hEA;

   localparam logic [2:0] ST_RST = 3'd0;
   localparam logic [2:0] ST_RV0 = 3'd1;
   localparam logic [2:0] ST_RV1 = 3'd2;
   localparam logic [2:0] ST_RV2 = 3'd3;
   localparam logic [2:0] ST_T1  = 3'd4;
   localparam logic [2:0] ST_T2  = 3'd5;
   localparam logic [2:0] ST_T3  = 3'd6;

   typedef enum logic [2:0] {
      TS_RST = ST_RST,
      TS_RV0 = ST_RV0,
      TS_RV1 = ST_RV1,
      TS_RV2 = ST_RV2,
      TS_T1  = ST_T1,
      TS_T2  = ST_T2,
      TS_T3  = ST_T3
   } timing_state_t;

   typedef enum logic [2:0] {
      IMM_A,
      IMM_X,
      IMM_Y,
      XFER,
      JMP_ABS,
      NOP,
      ILLEGAL
   } inst_class_t;

   typedef enum logic [1:0] {
      REG_NONE,
      REG_AC,
      REG_X,
      REG_Y
   } reg_sel_t;

   function automatic inst_class_t decode_class(input logic [7:0] op);
      inst_class_t c;
      case (op)
         OP_LDA_IMM: c = IMM_A;
         OP_LDX_IMM: c = IMM_X;
         OP_LDY_IMM: c = IMM_Y;
         OP_TAX,
         OP_TAY,
         OP_TXA,
         OP_TYA:     c = XFER;
         OP_JMP_ABS: c = JMP_ABS;
         OP_NOP:     c = NOP;
         default:    c = ILLEGAL;
      endcase
      return c;
   endfunction

   // Unknown opcodes are treated as single-byte so the operand byte is not skipped.
   function automatic logic is_one_byte(input inst_class_t c);
      return (c == XFER) || (c == NOP) || (c == ILLEGAL);
   endfunction

endpackage

// File: rtl/k6502_decode.sv
// rtl/k6502_decode.sv - opcode to instruction class, with the source and
// destination register selects used by transfers and immediate loads.
module k6502_decode
   import k6502_pkg::*;
(
   input  logic [7:0]  i_opcode,
   output inst_class_t o_class,
   output reg_sel_t    o_src,
   output reg_sel_t    o_dst
);

   always_comb begin
      o_class = decode_class(i_opcode);
      o_src   = REG_NONE;
      o_dst   = REG_NONE;
      case (i_opcode)
         OP_LDA_IMM: o_dst = REG_AC;
         OP_LDX_IMM: o_dst = REG_X;
         OP_LDY_IMM: o_dst = REG_Y;
         OP_TAX: begin
            o_src = REG_AC;
            o_dst = REG_X;
         end
         OP_TAY: begin
            o_src = REG_AC;
            o_dst = REG_Y;
         end
         OP_TXA: begin
            o_src = REG_X;
            o_dst = REG_AC;
         end
         OP_TYA: begin
            o_src = REG_Y;
            o_dst = REG_AC;
         end
         default: begin
            o_src = REG_NONE;
            o_dst = REG_NONE;
         end
      endcase
   end

endmodule

// File: rtl/k6502_timing.sv
// rtl/k6502_timing.sv - k6502 timing/control sequencer: reset-vector fetch,
// opcode latch and per-state control bundle for the first opcode subset.
module k6502_timing
   import k6502_pkg::*;
(
   input  logic             ph0,
   input  logic             reset_n,
   input  logic [7:0]       pd,
   input  logic             rdy,
   output control_signals_t ctl,
   output logic [7:0]       ir,
   output logic             sync,
   output logic             illegal
);

   timing_state_t    r_state;
   logic [7:0]       r_ir;

   timing_state_t    w_next;
   control_signals_t w_ctl;
   logic             w_sync;
   logic             w_illegal;
   logic             w_advance;
   inst_class_t      w_pd_class;
   inst_class_t      w_ir_class;
   reg_sel_t         w_ir_src;
   reg_sel_t         w_ir_dst;

   k6502_decode u_decode (
      .i_opcode (r_ir),
      .o_class  (w_ir_class),
      .o_src    (w_ir_src),
      .o_dst    (w_ir_dst)
   );

   function automatic control_signals_t put_src(input control_signals_t c, input reg_sel_t s);
      control_signals_t r;
      r = c;
      case (s)
         REG_AC:  r.ac_sb = 1'b1;
         REG_X:   r.x_sb  = 1'b1;
         REG_Y:   r.y_sb  = 1'b1;
         default: r = c;
      endcase
      return r;
   endfunction

   function automatic control_signals_t put_dst(input control_signals_t c, input reg_sel_t d);
      control_signals_t r;
      r = c;
      case (d)
         REG_AC:  r.sb_ac = 1'b1;
         REG_X:   r.sb_x  = 1'b1;
         REG_Y:   r.sb_y  = 1'b1;
         default: r = c;
      endcase
      return r;
   endfunction

   assign w_advance  = rdy || (r_state == TS_RST);
   assign w_pd_class = decode_class(pd);

   always_ff @(posedge ph0 or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= TS_RST;
         r_ir    <= OP_NOP;
      end else begin
         if (w_advance) begin
            r_state <= w_next;
         end
         if ((r_state == TS_T1) && rdy) begin
            r_ir <= pd;
         end
      end
   end

   always_comb begin
      w_ctl     = CTL_HOLD;
      w_next    = r_state;
      w_sync    = 1'b0;
      w_illegal = 1'b0;
      case (r_state)
         TS_RST: begin
            w_next = TS_RV0;
         end
         TS_RV0: begin
            w_ctl.z_adl0  = 1'b1;
            w_ctl.z_adl1  = 1'b1;
            w_ctl.adl_abl = 1'b1;
            w_ctl.adh_abh = 1'b1;
            w_next        = TS_RV1;
         end
         TS_RV1: begin
            w_ctl.z_adl1  = 1'b1;
            w_ctl.adl_abl = 1'b1;
            w_ctl.adh_abh = 1'b1;
            w_ctl.dl_db   = 1'b1;
            w_ctl.db_add  = 1'b1;
            w_ctl.z_add   = 1'b1;
            w_next        = TS_RV2;
         end
         TS_RV2: begin
            w_ctl  = CTL_PC_LOAD;
            w_next = TS_T1;
         end
         TS_T1: begin
            // The opcode is not in ir yet, so this cycle decodes straight from pd.
            w_sync     = 1'b1;
            w_ctl      = CTL_FETCH;
            w_ctl.i_pc = !is_one_byte(w_pd_class);
            w_next     = TS_T2;
         end
         TS_T2: begin
            case (w_ir_class)
               IMM_A, IMM_X, IMM_Y: begin
                  w_ctl.dl_db  = 1'b1;
                  w_ctl.db_add = 1'b1;
                  w_ctl.z_add  = 1'b1;
                  w_next       = TS_T3;
               end
               XFER: begin
                  w_ctl  = put_dst(put_src(CTL_FETCH, w_ir_src), w_ir_dst);
                  w_next = TS_T1;
               end
               JMP_ABS: begin
                  w_ctl        = CTL_FETCH;
                  w_ctl.dl_db  = 1'b1;
                  w_ctl.db_add = 1'b1;
                  w_ctl.z_add  = 1'b1;
                  w_next       = TS_T3;
               end
               NOP: begin
                  w_ctl  = CTL_FETCH;
                  w_next = TS_T1;
               end
               default: begin
                  w_ctl     = CTL_FETCH;
                  w_illegal = 1'b1;
                  w_next    = TS_T1;
               end
            endcase
         end
         TS_T3: begin
            case (w_ir_class)
               IMM_A, IMM_X, IMM_Y: begin
                  w_ctl            = put_dst(CTL_FETCH, w_ir_dst);
                  w_ctl.add_sb_6_0 = 1'b1;
                  w_ctl.add_sb_7   = 1'b1;
               end
               JMP_ABS: w_ctl = CTL_PC_LOAD;
               default: w_ctl = CTL_FETCH;
            endcase
            w_next = TS_T1;
         end
         default: begin
            w_next = TS_RST;
         end
      endcase
      // A stall must not leak an increment or register load into the datapath.
      if (!rdy) begin
         w_ctl = CTL_HOLD;
      end
   end

   assign ctl     = w_ctl;
   assign ir      = r_ir;
   assign sync    = w_sync;
   assign illegal = w_illegal;

endmodule

// File: tb/tb_k6502_timing.sv
// tb/tb_k6502_timing.sv - scoreboard bench for k6502_timing: reset vector,
// LDX/TYA/JMP/illegal sequences, stalls and mid-instruction reset.
module tb_k6502_timing;
   import k6502_pkg::*;

   logic             ph0;
   logic             reset_n;
   logic [7:0]       pd;
   logic             rdy;
   control_signals_t ctl;
   logic [7:0]       ir;
   logic             sync;
   logic             illegal;

   int n_checks = 0;
   int n_fails  = 0;

   typedef struct {
      string            tag;
      control_signals_t ctl;
      logic             sync;
      logic             illegal;
      logic [7:0]       ir;
   } exp_t;

   exp_t sb[$];

   k6502_timing dut (
      .ph0     (ph0),
      .reset_n (reset_n),
      .pd      (pd),
      .rdy     (rdy),
      .ctl     (ctl),
      .ir      (ir),
      .sync    (sync),
      .illegal (illegal)
   );

   initial ph0 = 1'b0;
   always #5 ph0 = ~ph0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic control_signals_t e_hold();
      control_signals_t c;
      c = '0;
      c.pcl_pcl = 1'b1;
      c.pch_pch = 1'b1;
      return c;
   endfunction

   function automatic control_signals_t e_fetch(input logic ipc);
      control_signals_t c;
      c = e_hold();
      c.pcl_adl = 1'b1;
      c.adl_abl = 1'b1;
      c.pch_adh = 1'b1;
      c.adh_abh = 1'b1;
      c.i_pc    = ipc;
      return c;
   endfunction

   function automatic control_signals_t e_pcload();
      control_signals_t c;
      c = '0;
      c.dl_adh     = 1'b1;
      c.adh_pch    = 1'b1;
      c.adh_abh    = 1'b1;
      c.add_sb_6_0 = 1'b1;
      c.add_sb_7   = 1'b1;
      c.add_adl    = 1'b1;
      c.adl_pcl    = 1'b1;
      c.adl_abl    = 1'b1;
      c.i_pc       = 1'b1;
      return c;
   endfunction

   function automatic control_signals_t e_load_add(input control_signals_t base);
      control_signals_t c;
      c = base;
      c.dl_db  = 1'b1;
      c.db_add = 1'b1;
      c.z_add  = 1'b1;
      return c;
   endfunction

   // Advance one edge, drive inputs, and queue what the DUT must show this cycle.
   task automatic step(input logic [7:0] p, input logic r, input string tag,
                       input control_signals_t c, input logic s, input logic il,
                       input logic [7:0] i);
      exp_t e;
      @(posedge ph0);
      #1;
      pd  = p;
      rdy = r;
      e.tag = tag; e.ctl = c; e.sync = s; e.illegal = il; e.ir = i;
      sb.push_back(e);
   endtask

   always @(negedge ph0) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check({e.tag, ".ctl"},     32'(ctl),     32'(e.ctl));
         check({e.tag, ".sync"},    32'(sync),    32'(e.sync));
         check({e.tag, ".illegal"}, 32'(illegal), 32'(e.illegal));
         check({e.tag, ".ir"},      32'(ir),      32'(e.ir));
      end
   end

   initial begin
      control_signals_t c;
      reset_n = 1'b0;
      rdy     = 1'b1;
      pd      = 8'h00;
      repeat (3) @(posedge ph0);
      #1;
      check("rst.ctl",  32'(ctl),  32'(e_hold()));
      check("rst.sync", 32'(sync), 32'd0);
      check("rst.ir",   32'(ir),   32'hEA);
      reset_n = 1'b1;

      c = '0; c.z_adl0 = 1'b1; c.z_adl1 = 1'b1; c.adl_abl = 1'b1; c.adh_abh = 1'b1;
      c.pcl_pcl = 1'b1; c.pch_pch = 1'b1;
      step(8'h00, 1'b1, "rv0", c, 1'b0, 1'b0, 8'hEA);
      c = e_load_add(e_hold()); c.z_adl1 = 1'b1; c.adl_abl = 1'b1; c.adh_abh = 1'b1;
      step(8'h12, 1'b1, "rv1", c, 1'b0, 1'b0, 8'hEA);
      step(8'h34, 1'b1, "rv2", e_pcload(), 1'b0, 1'b0, 8'hEA);

      step(8'hA2, 1'b1, "ldx_t1", e_fetch(1'b1), 1'b1, 1'b0, 8'hEA);
      step(8'h5A, 1'b1, "ldx_t2", e_load_add(e_hold()), 1'b0, 1'b0, 8'hA2);
      c = e_fetch(1'b1); c.add_sb_6_0 = 1'b1; c.add_sb_7 = 1'b1; c.sb_x = 1'b1;
      step(8'h00, 1'b1, "ldx_t3", c, 1'b0, 1'b0, 8'hA2);

      step(8'h98, 1'b1, "tya_t1", e_fetch(1'b0), 1'b1, 1'b0, 8'hA2);
      c = e_fetch(1'b1); c.y_sb = 1'b1; c.sb_ac = 1'b1;
      step(8'h00, 1'b1, "tya_t2", c, 1'b0, 1'b0, 8'h98);

      step(8'h4C, 1'b1, "jmp_t1", e_fetch(1'b1), 1'b1, 1'b0, 8'h98);
      step(8'h00, 1'b1, "jmp_t2", e_load_add(e_fetch(1'b1)), 1'b0, 1'b0, 8'h4C);
      step(8'hC0, 1'b1, "jmp_t3", e_pcload(), 1'b0, 1'b0, 8'h4C);

      step(8'h02, 1'b1, "ill_t1", e_fetch(1'b0), 1'b1, 1'b0, 8'h4C);
      step(8'h00, 1'b1, "ill_t2", e_fetch(1'b1), 1'b0, 1'b1, 8'h02);

      step(8'hA9, 1'b1, "lda_t1", e_fetch(1'b1), 1'b1, 1'b0, 8'h02);
      step(8'h77, 1'b1, "lda_t2", e_load_add(e_hold()), 1'b0, 1'b0, 8'hA9);
      step(8'h00, 1'b0, "lda_t3_stall0", e_hold(), 1'b0, 1'b0, 8'hA9);
      step(8'h00, 1'b0, "lda_t3_stall1", e_hold(), 1'b0, 1'b0, 8'hA9);
      c = e_fetch(1'b1); c.add_sb_6_0 = 1'b1; c.add_sb_7 = 1'b1; c.sb_ac = 1'b1;
      step(8'h00, 1'b1, "lda_t3", c, 1'b0, 1'b0, 8'hA9);

      step(8'hA0, 1'b0, "ldy_t1_stall", e_hold(), 1'b1, 1'b0, 8'hA9);
      step(8'hA0, 1'b1, "ldy_t1", e_fetch(1'b1), 1'b1, 1'b0, 8'hA9);
      step(8'h11, 1'b1, "ldy_t2", e_load_add(e_hold()), 1'b0, 1'b0, 8'hA0);

      @(negedge ph0);
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst.ctl",     32'(ctl),     32'(e_hold()));
      check("midrst.ir",      32'(ir),      32'hEA);
      check("midrst.sync",    32'(sync),    32'd0);
      check("midrst.illegal", 32'(illegal), 32'd0);
      @(posedge ph0);
      #1;
      check("midrst_hold.ir", 32'(ir), 32'hEA);
      reset_n = 1'b1;
      c = '0; c.z_adl0 = 1'b1; c.z_adl1 = 1'b1; c.adl_abl = 1'b1; c.adh_abh = 1'b1;
      c.pcl_pcl = 1'b1; c.pch_pch = 1'b1;
      step(8'h00, 1'b1, "rv0_again", c, 1'b0, 1'b0, 8'hEA);

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge ph0);
      #1;
      if (sb.size() > 0) begin
         check("scoreboard_drain", 32'(sb.size()), 32'd0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
